bridge_lift_ctrl: RTL
=====================

# bridge_lift_ctrl

Parametrised drawbridge sequencer, the next generation of the lifting-bridge state machine. It adds per-lane deck occupancy sensing, cycle-counted warning and hold intervals, motor travel timeouts, re-raise on a boat arriving mid-lowering, and a latched fault state with operator clear. It sits between the raw bridge sensors/limit switches and the motor contactors, road traffic light, boat light and alarm.

## Interface
- N_LANES, 2: number of road-deck occupancy sensors (≥1)
- WARN_CYC, 8: consecutive clear-deck cycles required in WARN before raising (≥1)
- TRAVEL_MAX, 32: max cycles in RAISE/LOWER before fault (≥2)
- HOLD_CYC, 4: consecutive boat-clear cycles in OPEN before lowering (≥1)

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- BoatReq  in  1  boat approaching / waiting
- BoatClr  in  1  boat has passed the channel
- RoadOcc  in  N_LANES  vehicle on deck, one bit per lane
- UpLim  in  1  bridge fully-up limit switch
- DnLim  in  1  bridge fully-down limit switch
- FltClr  in  1  operator fault acknowledge
- MT_UP  out  1  raise motor
- MT_DN  out  1  lower motor
- AL  out  1  alarm/bell
- TFL  out  1  road light red (0 = green)
- BL  out  1  boat light green
- FLT  out  1  fault indicator
- State  out  3  current state encoding (debug)

## Operation
- Moore machine; all outputs decoded from the state register only.
- States and outputs (unlisted = 0):
  - IDLE: none
  - WARN: AL, TFL
  - RAISE: MT_UP, AL, TFL
  - OPEN: TFL, BL
  - LOWER: MT_DN, AL, TFL
  - FAULT: AL, TFL, FLT
- Shared timer tmr is cleared on every state change and otherwise incremented per state rule, saturating at max.
- IDLE: BoatReq=1 → WARN.
- WARN: tmr increments when RoadOcc==0 and clears when any bit is set. → RAISE on the edge where tmr==WARN_CYC-1 and RoadOcc==0.
- RAISE: UpLim=1 → OPEN. Otherwise, tmr==TRAVEL_MAX-1 → FAULT.
- OPEN: tmr increments when BoatClr=1 and BoatReq=0, else clears. → LOWER when tmr==HOLD_CYC-1 under that condition.
- LOWER, in priority order:
  - BoatReq=1 → RAISE (re-raise)
  - else DnLim=1 → IDLE
  - else tmr==TRAVEL_MAX-1 → FAULT
- FAULT is latched. FltClr=1 with DnLim=1 and UpLim=0 → IDLE. FltClr=1 with DnLim=0 and UpLim=0 → LOWER. Otherwise stay.
- Global, highest priority from any state: UpLim=1 and DnLim=1 → FAULT. While both are high, FltClr is ignored.
- MT_UP and MT_DN are never both 1 (guaranteed by decode).

## Timing
- Reset asserted (Reset=0): state=IDLE and all outputs 0 immediately, without waiting for Clock. State=0. Normal operation resumes on the first rising edge after release.
- Reset mid-operation (e.g. in RAISE) drops the motors asynchronously. No state is retained.
- State changes take effect on the rising edge. Outputs follow in the same cycle, so inputs-to-outputs latency is 1 cycle.
- With the deck clear, WARN lasts exactly WARN_CYC cycles.
- RAISE/LOWER fault fires exactly TRAVEL_MAX cycles after entry if the limit switch never asserts.
- OPEN lasts ≥HOLD_CYC cycles.
- Timer width: $clog2(max(WARN_CYC,TRAVEL_MAX,HOLD_CYC)+1).
- Inputs are assumed synchronous to Clock. Synchronizers are external.

## Structure
- Package bridge_lift_pkg holds:
  - 3-bit state encoding: IDLE=0, WARN=1, RAISE=2, OPEN=3, LOWER=4, FAULT=5
  - default parameter constants
- Sub-module lift_timer: saturating counter with clear and enable inputs and parametrised width. The FSM drives clear on state change and enable per the state rule.
- Top: state register, next-state logic, output decode.

## Test plan
- Reset, then BoatReq=1 for 1 cycle, RoadOcc=0, UpLim raised 5 cycles after RAISE entry, then BoatClr=1 for 4 cycles, then DnLim=1:
  - WARN for 8 cycles with AL=TFL=1
  - RAISE with MT_UP=1
  - OPEN with BL=1
  - LOWER for ≥1 cycle, then IDLE with all outputs 0
- RoadOcc=2'b10 asserted on WARN cycle 5 for 3 cycles → RAISE entered exactly 8 cycles after RoadOcc returns to 0.
- RAISE with UpLim held 0 → FAULT exactly 32 cycles after RAISE entry. Response:
  - FLT=1, MT_UP=0
  - FltClr with DnLim=0 → LOWER
  - DnLim=1 → IDLE
- BoatReq=1 on LOWER cycle 3 → RAISE on next edge, with MT_DN 1→0 and MT_UP 0→1 on the same edge.
- UpLim=DnLim=1 while OPEN → FAULT next edge. FltClr is ignored while both are high. Releasing UpLim then pulsing FltClr → IDLE.
- Reset=0 mid-RAISE, between clock edges → MT_UP, AL, TFL fall immediately and State=0.

Source files
------------

// File: rtl/bridge_lift_pkg.sv
// Shared definitions for the drawbridge sequencer.
// Holds the 3-bit state encoding, the default parameter values and a small
// helper used to size the shared interval timer.
package bridge_lift_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWarn  = 3'd1,
        StRaise = 3'd2,
        StOpen  = 3'd3,
        StLower = 3'd4,
        StFault = 3'd5
    } state_e;

    localparam int unsigned DefNLanes    = 2;
    localparam int unsigned DefWarnCyc   = 8;
    localparam int unsigned DefTravelMax = 32;
    localparam int unsigned DefHoldCyc   = 4;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bridge_lift_ctrl_timer.sv
// lift_timer: saturating up-counter with synchronous clear and count enable.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset, clears the count
//   i_clr   - synchronous clear, wins over i_en
//   i_en    - count enable; the count holds at all-ones
//   o_cnt   - current count
module lift_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bridge_lift_ctrl.sv
// bridge_lift_ctrl: drawbridge lift sequencer (Moore machine).
// Sequences IDLE -> WARN -> RAISE -> OPEN -> LOWER -> IDLE with a latched
// FAULT state. Outputs are decoded from the state register only.
// Ports:
//   i_clk, i_rst_n       - clock and asynchronous active-low reset
//   i_boat_req           - boat approaching / waiting
//   i_boat_clr           - boat has passed the channel
//   i_road_occ           - deck occupancy, one bit per lane
//   i_up_lim, i_dn_lim   - fully-up / fully-down limit switches
//   i_flt_clr            - operator fault acknowledge
//   o_mt_up, o_mt_dn     - raise / lower motor contactors
//   o_al, o_tfl, o_bl    - alarm, road light red, boat light green
//   o_flt                - fault indicator
//   o_state              - current state encoding
module bridge_lift_ctrl
    import bridge_lift_pkg::*;
#(
    parameter int unsigned N_LANES    = DefNLanes,
    parameter int unsigned WARN_CYC   = DefWarnCyc,
    parameter int unsigned TRAVEL_MAX = DefTravelMax,
    parameter int unsigned HOLD_CYC   = DefHoldCyc
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_boat_req,
    input  logic               i_boat_clr,
    input  logic [N_LANES-1:0] i_road_occ,
    input  logic               i_up_lim,
    input  logic               i_dn_lim,
    input  logic               i_flt_clr,
    output logic               o_mt_up,
    output logic               o_mt_dn,
    output logic               o_al,
    output logic               o_tfl,
    output logic               o_bl,
    output logic               o_flt,
    output logic [2:0]         o_state
);

    localparam int unsigned TmrMax = max3(WARN_CYC, TRAVEL_MAX, HOLD_CYC);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [TmrW-1:0] WarnLast   = TmrW'(WARN_CYC - 1);
    localparam logic [TmrW-1:0] TravelLast = TmrW'(TRAVEL_MAX - 1);
    localparam logic [TmrW-1:0] HoldLast   = TmrW'(HOLD_CYC - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [TmrW-1:0] w_tmr;
    logic            w_tmr_en;
    logic            w_tmr_rule_clr;
    logic            w_tmr_clr;
    logic            w_road_clear;
    logic            w_boat_gone;

    assign w_road_clear = (i_road_occ == '0);
    assign w_boat_gone  = i_boat_clr & ~i_boat_req;

    lift_timer #(
        .WIDTH (TmrW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_cnt   (w_tmr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_en       = 1'b0;
        w_tmr_rule_clr = 1'b0;
        // Both limit switches at once means a broken sensor or structure:
        // override everything, including an operator clear.
        if (i_up_lim && i_dn_lim) begin
            w_state_nxt = StFault;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_boat_req) w_state_nxt = StWarn;
                end
                StWarn: begin
                    // The clear-deck interval restarts whenever a lane is occupied.
                    if (w_road_clear) begin
                        w_tmr_en = 1'b1;
                        if (w_tmr == WarnLast) w_state_nxt = StRaise;
                    end else begin
                        w_tmr_rule_clr = 1'b1;
                    end
                end
                StRaise: begin
                    w_tmr_en = 1'b1;
                    if (i_up_lim) begin
                        w_state_nxt = StOpen;
                    end else if (w_tmr == TravelLast) begin
                        w_state_nxt = StFault;
                    end
                end
                StOpen: begin
                    if (w_boat_gone) begin
                        w_tmr_en = 1'b1;
                        if (w_tmr == HoldLast) w_state_nxt = StLower;
                    end else begin
                        w_tmr_rule_clr = 1'b1;
                    end
                end
                StLower: begin
                    w_tmr_en = 1'b1;
                    if (i_boat_req) begin
                        w_state_nxt = StRaise;
                    end else if (i_dn_lim) begin
                        w_state_nxt = StIdle;
                    end else if (w_tmr == TravelLast) begin
                        w_state_nxt = StFault;
                    end
                end
                StFault: begin
                    if (i_flt_clr && !i_up_lim) begin
                        w_state_nxt = i_dn_lim ? StIdle : StLower;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
        w_tmr_clr = w_tmr_rule_clr | (w_state_nxt != r_state);
    end

    // Moore output decode; only one motor state drives each contactor.
    always_comb begin
        o_mt_up = 1'b0;
        o_mt_dn = 1'b0;
        o_al    = 1'b0;
        o_tfl   = 1'b0;
        o_bl    = 1'b0;
        o_flt   = 1'b0;
        unique case (r_state)
            StIdle: begin
            end
            StWarn: begin
                o_al  = 1'b1;
                o_tfl = 1'b1;
            end
            StRaise: begin
                o_mt_up = 1'b1;
                o_al    = 1'b1;
                o_tfl   = 1'b1;
            end
            StOpen: begin
                o_tfl = 1'b1;
                o_bl  = 1'b1;
            end
            StLower: begin
                o_mt_dn = 1'b1;
                o_al    = 1'b1;
                o_tfl   = 1'b1;
            end
            StFault: begin
                o_al  = 1'b1;
                o_tfl = 1'b1;
                o_flt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_state = r_state;

endmodule
